// File: rtl/lab3_mem_blocking_cache_param.sv
// rtl/lab3_mem_blocking_cache_param.sv - blocking write-back cache, 1/2-way, optional stats (LAB3_MEM_CACHE_STATS_EN)
// Message layouts, MSB first:
//   mem_req_4B_t   [76:0]  {type_[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}
//   mem_resp_4B_t  [46:0]  {type_[2:0], opaque[7:0], test[1:0], len[1:0], data[31:0]}
//   mem_req_16B_t  [174:0] {type_[2:0], opaque[7:0], addr[31:0], len[3:0], data[127:0]}
//   mem_resp_16B_t [144:0] {type_[2:0], opaque[7:0], test[1:0], len[3:0], data[127:0]}
module lab3_mem_blocking_cache_param #(
  parameter int p_num_bytes = 256,
  parameter int p_num_ways  = 2,
  parameter int p_idx_shamt = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cachereq_val,
  output logic         cachereq_rdy,
  input  logic [76:0]  cachereq_msg,
  output logic         cacheresp_val,
  input  logic         cacheresp_rdy,
  output logic [46:0]  cacheresp_msg,
  output logic         memreq_val,
  input  logic         memreq_rdy,
  output logic [174:0] memreq_msg,
  input  logic         memresp_val,
  output logic         memresp_rdy,
  input  logic [144:0] memresp_msg
`ifdef LAB3_MEM_CACHE_STATS_EN
  ,
  output logic [31:0]  stat_hits,
  output logic [31:0]  stat_misses,
  output logic [31:0]  stat_evicts
`endif
);

  localparam int NSETS = p_num_bytes / (16 * p_num_ways);
  localparam int IDX_W = (NSETS > 1) ? $clog2(NSETS) : 1;

  localparam logic [2:0] TYPE_READ  = 3'd0;
  localparam logic [2:0] TYPE_WRITE = 3'd1;
  localparam logic [2:0] TYPE_INIT  = 3'd2;

  typedef enum logic [3:0] {
    IDLE, TAG_CHECK, INIT, EVICT_PREP, EVICT_REQ, EVICT_WAIT,
    REFILL_REQ, REFILL_WAIT, REFILL_UPDATE, RD_WR, WAIT
  } state_t;

  state_t state, state_n;

  logic [2:0]   req_type;
  logic [7:0]   req_opaque;
  logic [31:0]  req_addr;
  logic [31:0]  req_data;
  logic         way_r;
  logic         hit_r;
  logic [127:0] line_r;
  logic [31:0]  evict_addr;
  logic [31:0]  rdata_r;

  // Way 1 storage exists in the 1-way build but is never selected.
  logic [27:0]  tag_q   [2][NSETS];
  logic         valid_q [2][NSETS];
  logic         dirty_q [2][NSETS];
  logic         lru_q   [NSETS];
  logic [127:0] data_q  [2][NSETS];

  logic [IDX_W-1:0] idx;
  logic [27:0]      tag;
  logic [1:0]       word;
  logic             hit0, hit1, hit, hit_way, victim, victim_dirty, sel_way;

  logic             data_wen;
  logic [15:0]      wr_ben;
  logic [127:0]     wr_line;
  logic [3:0]       word_en;
  logic [15:0]      word_ben;

  logic             unused_bits;
  assign unused_bits = ^{cachereq_msg[33:32], memresp_msg[144:128]};

  assign idx  = (NSETS > 1) ? IDX_W'(req_addr >> (p_idx_shamt + 4)) : '0;
  assign tag  = req_addr[31:4];
  assign word = req_addr[3:2];

  assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1    = (p_num_ways == 2) && valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit     = hit0 || hit1;
  assign hit_way = !hit0;

  // Victim: first invalid way (way 0 wins), otherwise the LRU way.
  always_comb begin
    victim = 1'b0;
    if (p_num_ways == 2) begin
      if (!valid_q[0][idx])      victim = 1'b0;
      else if (!valid_q[1][idx]) victim = 1'b1;
      else                       victim = lru_q[idx];
    end
  end

  assign victim_dirty = valid_q[victim][idx] && dirty_q[victim][idx];
  assign sel_way      = hit ? hit_way : victim;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_n       = state;
    cachereq_rdy  = 1'b0;
    cacheresp_val = 1'b0;
    memreq_val    = 1'b0;
    memresp_rdy   = 1'b0;
    case (state)
      IDLE: begin
        cachereq_rdy = 1'b1;
        if (cachereq_val) state_n = TAG_CHECK;
      end
      TAG_CHECK: begin
        if (req_type == TYPE_INIT) state_n = INIT;
        else if (hit)              state_n = RD_WR;
        else if (victim_dirty)     state_n = EVICT_PREP;
        else                       state_n = REFILL_REQ;
      end
      INIT:       state_n = WAIT;
      EVICT_PREP: state_n = EVICT_REQ;
      EVICT_REQ: begin
        memreq_val = 1'b1;
        if (memreq_rdy) state_n = EVICT_WAIT;
      end
      EVICT_WAIT: begin
        memresp_rdy = 1'b1;
        if (memresp_val) state_n = REFILL_REQ;
      end
      REFILL_REQ: begin
        memreq_val = 1'b1;
        if (memreq_rdy) state_n = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        memresp_rdy = 1'b1;
        if (memresp_val) state_n = REFILL_UPDATE;
      end
      REFILL_UPDATE: state_n = RD_WR;
      RD_WR:         state_n = WAIT;
      WAIT: begin
        cacheresp_val = 1'b1;
        if (cacheresp_rdy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign memreq_msg = {(state == EVICT_REQ) ? TYPE_WRITE : TYPE_READ, 8'h00,
                       (state == EVICT_REQ) ? evict_addr : {tag, 4'h0}, 4'h0, line_r};

  assign cacheresp_msg = {req_type, req_opaque, {1'b0, hit_r}, 2'b00,
                          (req_type == TYPE_READ) ? rdata_r : 32'h0};

  // Request latch, way/hit capture, evict and refill line buffer, read word.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_type   <= '0;
      req_opaque <= '0;
      req_addr   <= '0;
      req_data   <= '0;
      way_r      <= 1'b0;
      hit_r      <= 1'b0;
      line_r     <= '0;
      evict_addr <= '0;
      rdata_r    <= '0;
    end else begin
      case (state)
        IDLE: if (cachereq_val) begin
          req_type   <= cachereq_msg[76:74];
          req_opaque <= cachereq_msg[73:66];
          req_addr   <= cachereq_msg[65:34];
          req_data   <= cachereq_msg[31:0];
        end
        TAG_CHECK: begin
          way_r <= sel_way;
          hit_r <= hit && (req_type != TYPE_INIT);
        end
        EVICT_PREP: begin
          line_r     <= data_q[way_r][idx];
          evict_addr <= {tag_q[way_r][idx], 4'h0};
        end
        REFILL_WAIT: if (memresp_val) line_r <= memresp_msg[127:0];
        RD_WR:       rdata_r <= data_q[way_r][idx][{word, 5'b0} +: 32];
        default: ;
      endcase
    end
  end

  // Tag, valid, dirty and LRU state; LRU always points away from the way just used.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NSETS; s++) begin
        valid_q[0][s] <= 1'b0;
        valid_q[1][s] <= 1'b0;
        dirty_q[0][s] <= 1'b0;
        dirty_q[1][s] <= 1'b0;
        lru_q[s]      <= 1'b0;
      end
    end else begin
      case (state)
        INIT: begin
          tag_q[way_r][idx]   <= tag;
          valid_q[way_r][idx] <= 1'b1;
          dirty_q[way_r][idx] <= 1'b0;
          lru_q[idx]          <= ~way_r;
        end
        REFILL_UPDATE: begin
          tag_q[way_r][idx]   <= tag;
          valid_q[way_r][idx] <= 1'b1;
          dirty_q[way_r][idx] <= 1'b0;
        end
        RD_WR: begin
          if (req_type == TYPE_WRITE) dirty_q[way_r][idx] <= 1'b1;
          lru_q[idx] <= ~way_r;
        end
        default: ;
      endcase
    end
  end

  assign word_en  = 4'b0001 << word;
  assign word_ben = {{4{word_en[3]}}, {4{word_en[2]}}, {4{word_en[1]}}, {4{word_en[0]}}};

  // Data array write port select: whole-line refill or single replicated word.
  always_comb begin
    data_wen = 1'b0;
    wr_ben   = '0;
    wr_line  = {4{req_data}};
    case (state)
      INIT: begin
        data_wen = 1'b1;
        wr_ben   = word_ben;
      end
      REFILL_UPDATE: begin
        data_wen = 1'b1;
        wr_ben   = '1;
        wr_line  = line_r;
      end
      RD_WR: if (req_type == TYPE_WRITE) begin
        data_wen = 1'b1;
        wr_ben   = word_ben;
      end
      default: ;
    endcase
  end

  // Byte-enabled data array write.
  always_ff @(posedge clk) begin
    if (data_wen) begin
      for (int b = 0; b < 16; b++) begin
        if (wr_ben[b]) data_q[way_r][idx][b*8 +: 8] <= wr_line[b*8 +: 8];
      end
    end
  end

`ifdef LAB3_MEM_CACHE_STATS_EN
  // One hit or miss per non-init transaction; evicts counted on dirty-victim misses.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_evicts <= '0;
    end else if (state == TAG_CHECK && req_type != TYPE_INIT) begin
      if (hit) stat_hits <= stat_hits + 32'd1;
      else begin
        stat_misses <= stat_misses + 32'd1;
        if (victim_dirty) stat_evicts <= stat_evicts + 32'd1;
      end
    end
  end
`endif

endmodule
